// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler_pkg : shared types and helpers for the UART TX scheduler
// Rev 1.0
// ============================================================================
package uart_tx_scheduler_pkg;

  // Smallest w with 2**w >= value; constant-evaluable for port widths.
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// rr_priority_encoder : round-robin pick of the first request after last_grant
// Rev 1.0
// ============================================================================
module rr_priority_encoder
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = CeilLog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  localparam logic [IDX_W:0]   c_num_req  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   w_start;
  logic [NUM_REQ-1:0] w_req_rot;
  logic [IDX_W-1:0]   w_enc;
  logic [IDX_W:0]     w_sum;

  always_comb begin
    // Explicit wrap keeps the rotation correct when NUM_REQ is not a power of two.
    w_start   = (last_grant == c_last_idx) ? '0 : last_grant + 1'b1;
    w_req_rot = NUM_REQ'({req, req} >> w_start);
    w_enc     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_enc = IDX_W'(i);
    end
    w_sum = {1'b0, w_enc} + {1'b0, w_start};
    if (w_sum >= c_num_req) w_sum = w_sum - c_num_req;
    grant   = w_sum[IDX_W-1:0];
    any_req = |req;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : round-robin sharing of one UART TX serializer
// Rev 1.0
// ============================================================================
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LENGHT    = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_LENGHT-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [WORD_LENGHT-1:0]         tx_data,
  output logic                           tx_send,
  input  logic                           tx_done,
  output logic [CeilLog2(NUM_REQ)-1:0]   grant_id,
  output logic                           sched_busy,
  output logic                           timeout_err
);

  localparam int IDX_W = CeilLog2(NUM_REQ);
  localparam int CNT_W = CeilLog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_expire = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_REQ - 1);

  sched_state_t           state_q,       state_d;
  logic [NUM_REQ-1:0]     ack_q,         ack_d;
  logic [WORD_LENGHT-1:0] tx_data_q,     tx_data_d;
  logic                   tx_send_q,     tx_send_d;
  logic [IDX_W-1:0]       grant_id_q,    grant_id_d;
  logic                   sched_busy_q,  sched_busy_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]       last_grant_q,  last_grant_d;
  logic [CNT_W-1:0]       cnt_q,         cnt_d;

  logic [IDX_W-1:0]       w_grant;
  logic                   w_any_req;

  rr_priority_encoder #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_priority_encoder (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (w_grant),
    .any_req    (w_any_req)
  );

  always_comb begin
    state_d       = state_q;
    ack_d         = '0;
    tx_data_d     = tx_data_q;
    tx_send_d     = 1'b0;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        // Arbitration is held off while ack is visible, giving the acked
        // requester a cycle to drop or re-present its request.
        if (w_any_req && (ack_q == '0)) begin
          state_d    = SEND;
          tx_send_d  = 1'b1;
          grant_id_d = w_grant;
          tx_data_d  = req_data[int'(w_grant)*WORD_LENGHT +: WORD_LENGHT];
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_done) begin
          ack_d        = NUM_REQ'(1) << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else if (cnt_q == c_cnt_expire) begin
          timeout_err_d = 1'b1;
          last_grant_d  = grant_id_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sched_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      tx_data_q     <= '0;
      tx_send_q     <= 1'b0;
      grant_id_q    <= '0;
      sched_busy_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      last_grant_q  <= c_last_idx;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      tx_data_q     <= tx_data_d;
      tx_send_q     <= tx_send_d;
      grant_id_q    <= grant_id_d;
      sched_busy_q  <= sched_busy_d;
      timeout_err_q <= timeout_err_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign grant_id    = grant_id_q;
  assign sched_busy  = sched_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_scheduler : directed and randomized checks against a frame model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] ack;
  logic [W-1:0] tx_data;
  logic         tx_send;
  logic         tx_done;
  logic [1:0]   grant_id;
  logic         sched_busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ        (N),
    .WORD_LENGHT    (W),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int model_last;
  int next_gap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // First asserted requester after 'last', wrapping around.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  // One frame: await tx_send, play the serializer (delay 0 or >T = no done), check outcome.
  task automatic do_frame(input string tag, input int delay, input bit drop);
    int id, gap, outcome;
    logic [W-1:0] exp_data;
    bit seen, early, pulse_bad, timed_out;
    id        = rr_pick(req, model_last);
    exp_data  = req_data[id*W +: W];
    seen      = 1'b0;
    pulse_bad = 1'b0;
    gap       = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      gap = n;
      if (tx_send) seen = 1'b1;
      else if (ack != '0 || timeout_err) pulse_bad = 1'b1;
    end
    check_val({tag, " send_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check_val({tag, " pulse_width"}, 32'(pulse_bad), 32'd0);
    check_val({tag, " gap"}, gap, next_gap);
    check_val({tag, " grant_id"}, 32'(grant_id), id);
    check_val({tag, " tx_data"}, 32'(tx_data), 32'(exp_data));
    timed_out = (delay < 1 || delay > T);
    outcome   = timed_out ? T + 1 : delay + 1;
    early     = 1'b0;
    for (int k = 1; k <= outcome; k++) begin
      @(negedge clk);
      if (k < outcome) begin
        if (tx_send || ack != '0 || timeout_err || !sched_busy) early = 1'b1;
        tx_done = (k == delay);
        if (drop && k == 1) req[id] = 1'b0;
      end else begin
        tx_done = 1'b0;
      end
    end
    check_val({tag, " no_early"}, 32'(early), 32'd0);
    check_val({tag, " ack"}, 32'(ack), timed_out ? 32'd0 : (32'd1 << id));
    check_val({tag, " timeout_err"}, 32'(timeout_err), 32'(timed_out));
    check_val({tag, " busy_low"}, 32'(sched_busy), 32'd0);
    check_val({tag, " tx_data_hold"}, 32'(tx_data), 32'(exp_data));
    model_last = id;
    next_gap   = timed_out ? 1 : 2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    next_gap   = 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    next_gap = 1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] keep, fresh;
    bit seen;
    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    model_last = N - 1; next_gap = 1;
    repeat (2) @(negedge clk);
    check_val("rst ack", 32'(ack), 32'd0);
    check_val("rst tx_send", 32'(tx_send), 32'd0);
    check_val("rst tx_data", 32'(tx_data), 32'd0);
    check_val("rst grant_id", 32'(grant_id), 32'd0);
    check_val("rst busy", 32'(sched_busy), 32'd0);
    check_val("rst timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single requester, serializer finishes 10 cycles after start.
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    do_frame("single", 10, 1'b0);
    req = '0;

    // All requesting: fairness order 0,1,2,3,0.
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_frame("rr_all", 5, 1'b0);
    req = '0;

    // No tx_done: timeout, then re-grant with done exactly at expiry.
    do_reset();
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    do_frame("timeout", 0, 1'b0);
    do_frame("done_at_expiry", T, 1'b0);
    req = '0;

    // Reset in the middle of a frame.
    idle_cycles(2);
    req_data[15:8] = 8'h3C;
    req = 4'b0010;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (tx_send) seen = 1'b1;
    end
    check_val("midrst send_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst busy", 32'(sched_busy), 32'd0);
    check_val("midrst ack", 32'(ack), 32'd0);
    check_val("midrst tx_data", 32'(tx_data), 32'd0);
    check_val("midrst timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    model_last = N - 1;
    next_gap   = 1;
    do_frame("after_rst", 4, 1'b0);
    req = '0;

    // Stray tx_done while idle must be ignored.
    idle_cycles(2);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_val("stray ack", 32'(ack), 32'd0);
    check_val("stray busy", 32'(sched_busy), 32'd0);
    req_data[31:24] = 8'h5A;
    req = 4'b1000;
    next_gap = 1;
    do_frame("after_stray", 3, 1'b0);
    req = '0;

    // Randomized traffic.
    idle_cycles(2);
    req_data = N*W'($urandom);
    req = N'($urandom_range(1, (1 << N) - 1));
    for (int f = 0; f < 30; f++) begin
      do_frame("rnd", int'($urandom_range(1, T + 3)), ($urandom_range(0, 3) == 0));
      keep = req & ~(N'(1) << model_last);
      req_data[model_last*W +: W] = W'($urandom);
      if ($urandom_range(0, 1) == 1) keep[model_last] = 1'b1;
      fresh = N'($urandom_range(0, (1 << N) - 1)) & ~keep;
      for (int i = 0; i < N; i++) begin
        if (fresh[i] && i != model_last) req_data[i*W +: W] = W'($urandom);
      end
      req = keep | fresh;
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
    end
    req = '0;
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
